// File: rtl/if_axi_line_fetch.sv
// IF-stage instruction fetch master: one AXI4 INCR burst fills a single-line
// buffer, and later fetches that hit that line are answered without bus traffic.
module if_axi_line_fetch #(
    parameter int                ADDR_W    = 64,
    parameter int                DATA_W    = 64,
    parameter int                BURST_LEN = 4,
    parameter logic [3:0]        AXI_ID    = 4'd0,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_pc,
    input  logic              flush,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_instr,
    output logic [ADDR_W-1:0] rsp_pc,
    output logic              rsp_err,
    output logic              axi_idle,
    output logic              arvalid,
    input  logic              arready,
    output logic [3:0]        arid,
    output logic [ADDR_W-1:0] araddr,
    output logic [7:0]        arlen,
    output logic [2:0]        arsize,
    output logic [1:0]        arburst,
    input  logic [3:0]        rid,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp,
    input  logic              rlast,
    input  logic              rvalid,
    output logic              rready
);

    localparam int BEAT_B = DATA_W / 8;
    localparam int LB     = BURST_LEN * BEAT_B;
    localparam int OFF_W  = $clog2(LB);
    localparam int BYTE_W = $clog2(BEAT_B);
    localparam int IDX_W  = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int DEPTH  = 1 << IDX_W;
    localparam int TAG_W  = ADDR_W - OFF_W;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_AR    = 2'd1,
        S_RD    = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [ADDR_W-1:0] r_pc;
    logic [TAG_W-1:0]  r_tag;
    logic              r_line_valid;
    logic              r_line_err;
    logic              r_flush_pend;
    logic [IDX_W-1:0]  r_beat_cnt;
    logic              r_rsp_valid;
    logic [31:0]       r_rsp_instr;
    logic [ADDR_W-1:0] r_rsp_pc;
    logic              r_rsp_err;

    logic [TAG_W-1:0]  w_req_tag;
    logic [TAG_W-1:0]  w_pc_tag;
    logic [IDX_W-1:0]  w_req_idx;
    logic [IDX_W-1:0]  w_pc_idx;
    logic              w_hit;
    logic              w_accept;
    logic              w_hit_accept;
    logic              w_miss_accept;
    logic              w_beat;
    logic              w_last_beat;
    logic              w_fill_done;
    logic              w_beat_err;
    logic              w_rsp_fire;
    logic [DATA_W-1:0] w_fill_beat;
    logic [31:0]       w_hit_word;
    logic [31:0]       w_fill_word;
    logic              w_unused;

    // With 64-bit beats, pc[2] picks the 32-bit half.
    function automatic logic [31:0] f_sel(input logic [DATA_W-1:0] beat, input logic hi);
        if (DATA_W == 64 && hi)
            return beat[DATA_W-1:DATA_W-32];
        return beat[31:0];
    endfunction

    assign w_req_tag = req_pc[ADDR_W-1:OFF_W];
    assign w_pc_tag  = r_pc[ADDR_W-1:OFF_W];

    generate
        if (BURST_LEN > 1) begin : g_idx
            assign w_req_idx = req_pc[OFF_W-1:BYTE_W];
            assign w_pc_idx  = r_pc[OFF_W-1:BYTE_W];
        end else begin : g_idx_single
            assign w_req_idx = '0;
            assign w_pc_idx  = '0;
        end
    endgenerate

    assign w_hit         = r_line_valid && (w_req_tag == r_tag);
    assign w_accept      = req_valid && req_ready;
    assign w_hit_accept  = w_accept && w_hit;
    assign w_miss_accept = w_accept && !w_hit;
    assign w_beat_err    = (rresp != 2'b00);
    assign w_beat        = (r_state == S_RD) && rvalid && !flush;
    assign w_last_beat   = (r_state == S_RD) && rvalid && rlast;
    assign w_fill_done   = w_last_beat && !flush;
    assign w_rsp_fire    = rsp_valid && rsp_ready;

    // The final beat is not in the buffer yet when the response is formed.
    assign w_fill_beat = (w_pc_idx == r_beat_cnt) ? rdata : r_mem[w_pc_idx];
    assign w_fill_word = f_sel(w_fill_beat, r_pc[2]);
    assign w_hit_word  = f_sel(r_mem[w_req_idx], req_pc[2]);

    assign rsp_valid = r_rsp_valid && !flush;
    assign rsp_instr = r_rsp_instr;
    assign rsp_pc    = r_rsp_pc;
    assign rsp_err   = r_rsp_err;

    assign arid    = AXI_ID;
    assign araddr  = {w_pc_tag, {OFF_W{1'b0}}} + BASE_ADDR;
    assign arlen   = 8'(BURST_LEN - 1);
    assign arsize  = 3'(BYTE_W);
    assign arburst = 2'b01;

    assign w_unused = ^rid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_miss_accept)
                    w_state_next = S_AR;
            end
            S_AR: begin
                if (arready)
                    w_state_next = (r_flush_pend || flush) ? S_DRAIN : S_RD;
            end
            S_RD: begin
                if (rvalid && rlast)
                    w_state_next = S_IDLE;
                else if (flush)
                    w_state_next = S_DRAIN;
            end
            S_DRAIN: begin
                if (rvalid && rlast)
                    w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready = 1'b0;
        arvalid   = 1'b0;
        rready    = 1'b0;
        axi_idle  = 1'b0;
        case (r_state)
            S_IDLE: begin
                axi_idle  = 1'b1;
                req_ready = (!r_rsp_valid || rsp_ready) && !flush;
            end
            S_AR:          arvalid = 1'b1;
            S_RD, S_DRAIN: rready  = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_beat)
            r_mem[r_beat_cnt] <= rdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc         <= '0;
            r_tag        <= '0;
            r_line_valid <= 1'b0;
            r_line_err   <= 1'b0;
            r_flush_pend <= 1'b0;
            r_beat_cnt   <= '0;
        end else begin
            // A miss overwrites the buffer, so the old line is no longer trustworthy.
            if (w_miss_accept) begin
                r_pc         <= req_pc;
                r_line_valid <= 1'b0;
                r_flush_pend <= 1'b0;
            end
            if (r_state == S_AR) begin
                if (flush)
                    r_flush_pend <= 1'b1;
                if (arready) begin
                    r_beat_cnt <= '0;
                    r_line_err <= 1'b0;
                end
            end
            if (w_beat) begin
                r_beat_cnt <= r_beat_cnt + 1'b1;
                if (w_beat_err)
                    r_line_err <= 1'b1;
            end
            if (w_fill_done) begin
                r_tag        <= w_pc_tag;
                r_line_valid <= !(r_line_err || w_beat_err);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid <= 1'b0;
            r_rsp_instr <= '0;
            r_rsp_pc    <= '0;
            r_rsp_err   <= 1'b0;
        end else if (flush) begin
            r_rsp_valid <= 1'b0;
        end else if (w_hit_accept) begin
            r_rsp_valid <= 1'b1;
            r_rsp_instr <= w_hit_word;
            r_rsp_pc    <= req_pc;
            r_rsp_err   <= 1'b0;
        end else if (w_fill_done) begin
            r_rsp_valid <= 1'b1;
            r_rsp_instr <= w_fill_word;
            r_rsp_pc    <= r_pc;
            r_rsp_err   <= r_line_err || w_beat_err;
        end else if (w_rsp_fire) begin
            r_rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_if_axi_line_fetch.sv
// Scoreboard bench for if_axi_line_fetch: expected AR addresses and responses
// are queued at stimulus time and checked by a negedge monitor.
`timescale 1ns/1ps
module tb_if_axi_line_fetch;

    localparam int ADDR_W    = 64;
    localparam int DATA_W    = 64;
    localparam int BURST_LEN = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_pc;
    logic              flush;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_instr;
    logic [ADDR_W-1:0] rsp_pc;
    logic              rsp_err;
    logic              axi_idle;
    logic              arvalid;
    logic              arready;
    logic [3:0]        arid;
    logic [ADDR_W-1:0] araddr;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic [3:0]        rid;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              rready;

    always #5 clk = ~clk;

    if_axi_line_fetch #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .BURST_LEN(BURST_LEN),
        .AXI_ID   (4'd0),
        .BASE_ADDR(64'h0)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_pc   (req_pc),
        .flush    (flush),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_instr(rsp_instr),
        .rsp_pc   (rsp_pc),
        .rsp_err  (rsp_err),
        .axi_idle (axi_idle),
        .arvalid  (arvalid),
        .arready  (arready),
        .arid     (arid),
        .araddr   (araddr),
        .arlen    (arlen),
        .arsize   (arsize),
        .arburst  (arburst),
        .rid      (rid),
        .rdata    (rdata),
        .rresp    (rresp),
        .rlast    (rlast),
        .rvalid   (rvalid),
        .rready   (rready)
    );

    typedef struct {
        logic [31:0] instr;
        logic [63:0] pc;
        logic        err;
    } rsp_t;

    rsp_t        exp_rsp[$];
    logic [63:0] exp_ar[$];
    int          total = 0;
    int          bad   = 0;

    localparam logic [63:0] STRIDE1 = 64'h1;
    localparam logic [63:0] STRIDE2 = 64'h0000_0001_0000_0001;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%b want=%b", name, act, exp);
        end
    endtask

    task automatic fail_note(input string name);
        total++;
        bad++;
        $display("FAIL %s: got=no/unexpected event want=expected event", name);
    endtask

    task automatic push_rsp(input logic [31:0] instr, input logic [63:0] pc, input logic err);
        rsp_t e;
        e.instr = instr;
        e.pc    = pc;
        e.err   = err;
        exp_rsp.push_back(e);
    endtask

    task automatic issue_req(input logic [63:0] pc);
        int n = 0;
        req_pc    = pc;
        req_valid = 1'b1;
        @(negedge clk);
        while (!req_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!req_ready) fail_note("req_accept_timeout");
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic ar_accept();
        int n = 0;
        @(negedge clk);
        while (!arvalid && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!arvalid) fail_note("arvalid_timeout");
        @(posedge clk);
        #1;
        arready = 1'b1;
        @(posedge clk);
        #1;
        arready = 1'b0;
    endtask

    task automatic send_beats(input logic [63:0] base, input logic [63:0] stride,
                              input int first, input int last, input int err_idx);
        for (int i = first; i <= last; i++) begin
            int n = 0;
            rvalid = 1'b1;
            rdata  = base + stride * 64'(i);
            rlast  = (i == BURST_LEN - 1);
            rresp  = (i == err_idx) ? 2'b10 : 2'b00;
            @(negedge clk);
            while (!rready && n < 50) begin
                n++;
                @(negedge clk);
            end
            if (!rready) fail_note("rready_timeout");
            @(posedge clk);
            #1;
        end
        rvalid = 1'b0;
        rlast  = 1'b0;
        rresp  = 2'b00;
    endtask

    always @(negedge clk) begin : monitor
        rsp_t        e;
        logic [63:0] a;
        if (rst_n) begin
            if (rsp_valid && rsp_ready) begin
                $display("rsp  pc=%h instr=%h err=%b", rsp_pc, rsp_instr, rsp_err);
                if (exp_rsp.size() == 0) begin
                    fail_note("rsp_unexpected");
                end else begin
                    e = exp_rsp.pop_front();
                    chk("rsp_instr", 64'(rsp_instr), 64'(e.instr));
                    chk("rsp_pc", rsp_pc, e.pc);
                    chk1("rsp_err", rsp_err, e.err);
                end
            end
            if (arvalid && arready) begin
                $display("ar   addr=%h len=%0d size=%0d burst=%0d", araddr, arlen, arsize, arburst);
                if (exp_ar.size() == 0) begin
                    fail_note("ar_unexpected");
                end else begin
                    a = exp_ar.pop_front();
                    chk("araddr", araddr, a);
                    chk("arlen", 64'(arlen), 64'd3);
                    chk("arsize", 64'(arsize), 64'd3);
                    chk("arburst", 64'(arburst), 64'd1);
                    chk("arid", 64'(arid), 64'd0);
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_pc    = '0;
        flush     = 1'b0;
        rsp_ready = 1'b1;
        arready   = 1'b0;
        rid       = 4'd0;
        rdata     = '0;
        rresp     = 2'b00;
        rlast     = 1'b0;
        rvalid    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk1("rst_rsp_valid", rsp_valid, 1'b0);
        chk1("rst_req_ready", req_ready, 1'b1);
        chk1("rst_axi_idle", axi_idle, 1'b1);
        chk1("rst_arvalid", arvalid, 1'b0);
        chk1("rst_rready", rready, 1'b0);
        chk("rst_rsp_instr", 64'(rsp_instr), 64'h0);
        chk("rst_rsp_pc", rsp_pc, 64'h0);
        chk1("rst_rsp_err", rsp_err, 1'b0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Miss fill of line 0x1000
        exp_ar.push_back(64'h1000);
        push_rsp(32'h1111_0000, 64'h1004, 1'b0);
        issue_req(64'h1004);
        chk1("miss_arvalid", arvalid, 1'b1);
        chk1("miss_busy", axi_idle, 1'b0);
        ar_accept();
        send_beats(64'h1111_0000_2222_0000, STRIDE1, 0, 3, -1);
        chk1("fill_latency", rsp_valid, 1'b1);

        // Hits: no AR expected
        push_rsp(32'h2222_0003, 64'h1018, 1'b0);
        issue_req(64'h1018);
        chk1("hit_latency", rsp_valid, 1'b1);
        chk1("hit_no_ar", arvalid, 1'b0);
        push_rsp(32'h1111_0000, 64'h101C, 1'b0);
        issue_req(64'h101C);
        push_rsp(32'h2222_0001, 64'h1008, 1'b0);
        issue_req(64'h1008);
        @(posedge clk);
        #1;

        // Backpressure with a waiting hit
        rsp_ready = 1'b0;
        push_rsp(32'h2222_0002, 64'h1010, 1'b0);
        issue_req(64'h1010);
        push_rsp(32'h2222_0001, 64'h1008, 1'b0);
        req_pc    = 64'h1008;
        req_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk1("bp_valid", rsp_valid, 1'b1);
            chk("bp_instr", 64'(rsp_instr), 64'h2222_0002);
            chk("bp_pc", rsp_pc, 64'h1010);
            chk1("bp_req_ready", req_ready, 1'b0);
            @(posedge clk);
            #1;
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk1("bp_release_ready", req_ready, 1'b1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk1("b2b_valid", rsp_valid, 1'b1);
        chk("b2b_pc", rsp_pc, 64'h1008);
        @(posedge clk);
        #1;

        // Flush while AR is waiting for arready
        exp_ar.push_back(64'h2000);
        issue_req(64'h2000);
        for (int c = 0; c < 3; c++) begin
            flush = (c == 1);
            @(negedge clk);
            chk1("ar_hold", arvalid, 1'b1);
            @(posedge clk);
            #1;
        end
        flush   = 1'b0;
        arready = 1'b1;
        @(posedge clk);
        #1;
        arready = 1'b0;
        chk1("ar_drain_rready", rready, 1'b1);
        chk1("ar_drain_busy", axi_idle, 1'b0);
        send_beats(64'hDEAD_0000_BEEF_0000, STRIDE1, 0, 3, -1);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk1("ar_drain_no_rsp", rsp_valid, 1'b0);
        end
        chk1("ar_drain_idle", axi_idle, 1'b1);
        @(posedge clk);
        #1;
        exp_ar.push_back(64'h1000);
        push_rsp(32'h1111_0000, 64'h1004, 1'b0);
        issue_req(64'h1004);
        chk1("refetch_arvalid", arvalid, 1'b1);
        ar_accept();
        send_beats(64'h1111_0000_2222_0000, STRIDE1, 0, 3, -1);
        chk1("refetch_latency", rsp_valid, 1'b1);

        // Flush in RD after two beats
        exp_ar.push_back(64'h3000);
        issue_req(64'h3000);
        ar_accept();
        send_beats(64'h7777_0000_8888_0000, STRIDE2, 0, 1, -1);
        flush = 1'b1;
        @(negedge clk);
        chk1("rd_flush_rready", rready, 1'b1);
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk1("rd_drain_rready", rready, 1'b1);
        chk1("rd_drain_busy", axi_idle, 1'b0);
        send_beats(64'h7777_0000_8888_0000, STRIDE2, 2, 3, -1);
        @(negedge clk);
        chk1("rd_drain_no_rsp", rsp_valid, 1'b0);
        chk1("rd_drain_idle", axi_idle, 1'b1);
        @(posedge clk);
        #1;
        exp_ar.push_back(64'h3000);
        push_rsp(32'hAAAA_0001, 64'h300C, 1'b0);
        issue_req(64'h300C);
        ar_accept();
        send_beats(64'hAAAA_0000_BBBB_0000, STRIDE2, 0, 3, -1);

        // Error on beat 2, then an immediate refetch of the same line
        exp_ar.push_back(64'h4000);
        push_rsp(32'h6666_0002, 64'h4010, 1'b1);
        issue_req(64'h4010);
        ar_accept();
        send_beats(64'h5555_0000_6666_0000, STRIDE2, 0, 3, 2);
        chk1("err_latency", rsp_valid, 1'b1);
        exp_ar.push_back(64'h4000);
        push_rsp(32'h6666_0002, 64'h4010, 1'b0);
        issue_req(64'h4010);
        chk1("err_refetch_arvalid", arvalid, 1'b1);
        ar_accept();
        send_beats(64'h5555_0000_6666_0000, STRIDE2, 0, 3, -1);

        repeat (4) @(posedge clk);
        #1;
        chk("rsp_queue_left", 64'(exp_rsp.size()), 64'd0);
        chk("ar_queue_left", 64'(exp_ar.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
